// File: rtl/cache_refill_ctrl.sv
// Blocking single-outstanding miss handler: fetches one word from backing
// memory, writes it into the direct-mapped cache and returns it to the requester.
module cache_refill_ctrl #(
    parameter int unsigned ENTRY   = 8,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned IDX_W  = $clog2(ENTRY),
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_err,
    output logic              fill_en,
    output logic [IDX_W-1:0]  fill_index,
    output logic [TAG_W-1:0]  fill_tag,
    output logic [DATA_W-1:0] fill_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL,
        ST_RESP
    } state_t;

    localparam logic [15:0]       TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK   = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              err_q,   err_d;
    logic [15:0]       cnt_q,   cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        fill_en       = 1'b0;
        fill_index    = '0;
        fill_tag      = '0;
        fill_data     = '0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        rsp_err       = 1'b0;
        busy          = 1'b1;

        case (state_q)
            ST_IDLE: begin
                busy       = 1'b0;
                miss_ready = 1'b1;
                if (miss_valid) begin
                    addr_d  = miss_addr & ALIGN_MASK;
                    data_d  = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q;
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // A response on the expiry cycle takes priority over the timeout.
                if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        data_d  = mem_rsp_data;
                        state_d = ST_FILL;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = ST_RESP;
                end
            end

            ST_FILL: begin
                fill_en    = 1'b1;
                fill_index = addr_q[IDX_W+1:2];
                fill_tag   = addr_q[ADDR_W-1:IDX_W+2];
                fill_data  = data_q;
                state_d    = ST_RESP;
            end

            ST_RESP: begin
                fill_index = addr_q[IDX_W+1:2];
                fill_tag   = addr_q[ADDR_W-1:IDX_W+2];
                fill_data  = data_q;
                rsp_valid  = 1'b1;
                rsp_data   = data_q;
                rsp_err    = err_q;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a transaction scoreboard checks every
// cycle, while the main sequence pins cycle-exact expectations per scenario.
module tb_cache_refill_ctrl;

    localparam int ENTRY  = 8;
    localparam int IDX_W  = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 27;
    localparam int TMO    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              miss_valid;
    logic              miss_ready;
    logic [ADDR_W-1:0] miss_addr;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              mem_rsp_err;
    logic              fill_en;
    logic [IDX_W-1:0]  fill_index;
    logic [TAG_W-1:0]  fill_tag;
    logic [DATA_W-1:0] fill_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;

    cache_refill_ctrl #(
        .ENTRY  (ENTRY),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_valid   (miss_valid),
        .miss_ready   (miss_ready),
        .miss_addr    (miss_addr),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .mem_rsp_err  (mem_rsp_err),
        .fill_en      (fill_en),
        .fill_index   (fill_index),
        .fill_tag     (fill_tag),
        .fill_data    (fill_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        logic        data_care;
        int          fills;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [IDX_W-1:0] line_of(input logic [31:0] a);
        return IDX_W'((a >> 2) % ENTRY);
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
        return TAG_W'(a >> (IDX_W + 2));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic e,
                        input logic care, input int fills);
        txn_t t;
        t.addr = a; t.data = d; t.err = e; t.data_care = care; t.fills = fills;
        exp_q.push_back(t);
    endtask

    // Scoreboard: protocol rules and per-transaction expectations, every cycle.
    int          fill_cnt = 0;
    logic        req_hold = 1'b0;
    logic        rsp_hold = 1'b0;
    logic [31:0] held_addr;
    logic [32:0] held_rsp;

    always @(negedge clk) begin
        txn_t t;
        if (rst) begin
            fill_cnt = 0;
            req_hold = 1'b0;
            rsp_hold = 1'b0;
        end else begin
            chk("busy_vs_ready", 64'(busy), 64'(!miss_ready));
            if (miss_ready)
                chk("idle_outputs_zero",
                    {mem_req_valid, fill_en, rsp_valid, fill_index, fill_tag, fill_data}, '0);
            if (req_hold) begin
                chk("req_held", 64'(mem_req_valid), 64'd1);
                chk("req_addr_stable", 64'(mem_req_addr), 64'(held_addr));
            end
            if (rsp_hold) begin
                chk("rsp_held", 64'(rsp_valid), 64'd1);
                chk("rsp_stable", 64'({rsp_err, rsp_data}), 64'(held_rsp));
            end
            if (mem_req_valid || fill_en || rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_activity", 64'({mem_req_valid, fill_en, rsp_valid}), 64'd0);
                end else begin
                    t = exp_q[0];
                    if (mem_req_valid)
                        chk("mem_req_addr", 64'(mem_req_addr), 64'(t.addr & ~32'h3));
                    if (fill_en || (rsp_valid && t.fills != 0)) begin
                        chk("fill_index", 64'(fill_index), 64'(line_of(t.addr)));
                        chk("fill_tag", 64'(fill_tag), 64'(tag_of(t.addr)));
                        chk("fill_data", 64'(fill_data), 64'(t.data));
                    end
                    if (fill_en) fill_cnt++;
                    if (rsp_valid) begin
                        chk("rsp_err", 64'(rsp_err), 64'(t.err));
                        if (t.data_care) chk("rsp_data", 64'(rsp_data), 64'(t.data));
                        if (rsp_ready) begin
                            chk("fill_count", 64'(fill_cnt), 64'(t.fills));
                            fill_cnt = 0;
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
            req_hold  = mem_req_valid && !mem_req_ready;
            held_addr = mem_req_addr;
            rsp_hold  = rsp_valid && !rsp_ready;
            held_rsp  = {rsp_err, rsp_data};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0; rsp_ready = 1'b0;
        step(); step();
        chk("reset_miss_ready", 64'(miss_ready), 64'd1);
        chk("reset_outputs", 64'({busy, mem_req_valid, fill_en, rsp_valid, rsp_err}), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        rst = 1'b0;
        step();

        // Basic refill, zero-wait memory: accept c0, req c1, rsp c2, fill c3, rsp_valid c4
        push(32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 1'b1, 1);
        mem_req_ready = 1'b1;
        miss_valid = 1'b1; miss_addr = 32'h0000_1234;
        step();
        miss_valid = 1'b0;
        chk("t1_req_valid", 64'(mem_req_valid), 64'd1);
        chk("t1_req_addr", 64'(mem_req_addr), 64'h1234);
        step();
        chk("t1_wait_no_req", 64'(mem_req_valid), 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        step();
        mem_rsp_valid = 1'b0;
        chk("t1_fill_en", 64'(fill_en), 64'd1);
        chk("t1_fill_index", 64'(fill_index), 64'd5);
        chk("t1_fill_tag", 64'(fill_tag), 64'h91);
        chk("t1_fill_data", 64'(fill_data), 64'hDEAD_BEEF);
        chk("t1_no_rsp_in_fill", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b1;
        step();
        chk("t1_rsp_valid_c4", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_data", 64'(rsp_data), 64'hDEAD_BEEF);
        chk("t1_rsp_err", 64'(rsp_err), 64'd0);
        chk("t1_single_fill", 64'(fill_en), 64'd0);
        step();
        chk("t1_back_idle", 64'(miss_ready), 64'd1);

        // Unaligned address, request and response backpressure
        push(32'h0000_0013, 32'hCAFE_F00D, 1'b0, 1'b1, 1);
        mem_req_ready = 1'b0; rsp_ready = 1'b0;
        miss_valid = 1'b1; miss_addr = 32'h0000_0013;
        step();
        miss_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_req_hold", 64'({mem_req_valid, mem_req_addr}), 64'({1'b1, 32'h10}));
            step();
        end
        chk("t2_req_hold_last", 64'({mem_req_valid, mem_req_addr}), 64'({1'b1, 32'h10}));
        mem_req_ready = 1'b1;
        step();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
        step();
        mem_rsp_valid = 1'b0;
        chk("t2_fill", 64'({fill_en, fill_index, fill_tag}), 64'({1'b1, 3'd4, 27'd0}));
        step();
        for (int i = 0; i < 2; i++) begin
            chk("t2_rsp_hold", 64'({rsp_valid, rsp_data}), 64'({1'b1, 32'hCAFE_F00D}));
            step();
        end
        rsp_ready = 1'b1;
        chk("t2_rsp_final", 64'({rsp_valid, rsp_err, rsp_data}), 64'({2'b10, 32'hCAFE_F00D}));
        step();
        chk("t2_back_idle", 64'({miss_ready, rsp_valid}), 64'b10);

        // Bus error: no fill, error response
        push(32'h0000_ABCC, 32'h0, 1'b1, 1'b0, 0);
        miss_valid = 1'b1; miss_addr = 32'h0000_ABCC;
        step();
        miss_valid = 1'b0;
        step();
        mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1; mem_rsp_data = 32'h1234_5678;
        step();
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        chk("t3_err_rsp", 64'({fill_en, rsp_valid, rsp_err}), 64'b011);
        step();

        // Timeout: memory silent, response TMO cycles after entering WAIT
        push(32'h0000_0200, 32'h0, 1'b1, 1'b1, 0);
        miss_valid = 1'b1; miss_addr = 32'h0000_0200;
        step();
        miss_valid = 1'b0;
        step();
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("t4_timeout_latency", 64'(n), 64'd4);
        chk("t4_timeout_rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'({2'b11, 32'h0}));
        step();

        // Response landing on the expiry cycle wins over the timeout
        push(32'h0000_0204, 32'h55AA_33CC, 1'b0, 1'b1, 1);
        miss_valid = 1'b1; miss_addr = 32'h0000_0204;
        step();
        miss_valid = 1'b0;
        step();
        repeat (3) step();
        chk("t4b_still_waiting", 64'(rsp_valid), 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55AA_33CC;
        step();
        mem_rsp_valid = 1'b0;
        chk("t4b_fill", 64'({fill_en, fill_data}), 64'({1'b1, 32'h55AA_33CC}));
        step();
        chk("t4b_rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'({2'b10, 32'h55AA_33CC}));
        step();

        // Reset in WAIT, then a late response must be ignored
        push(32'h0000_0300, 32'h0, 1'b0, 1'b0, 1);
        miss_valid = 1'b1; miss_addr = 32'h0000_0300;
        step();
        miss_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        chk("t5_idle_after_rst", 64'({miss_ready, busy}), 64'b10);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0077;
        step();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_quiet", 64'({fill_en, rsp_valid, miss_ready}), 64'b001);
            step();
        end

        // Back-to-back misses with miss_valid held
        push(32'h0000_0040, 32'h1111_0040, 1'b0, 1'b1, 1);
        push(32'h0000_0044, 32'h2222_0044, 1'b0, 1'b1, 1);
        miss_valid = 1'b1; miss_addr = 32'h0000_0040;
        step();
        miss_addr = 32'h0000_0044;
        chk("t6_first_req", 64'(mem_req_addr), 64'h40);
        step();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_0040;
        step();
        mem_rsp_valid = 1'b0;
        chk("t6_fill0", 64'({fill_en, fill_index}), 64'({1'b1, 3'd0}));
        step();
        chk("t6_rsp0", 64'({rsp_valid, rsp_data}), 64'({1'b1, 32'h1111_0040}));
        chk("t6_not_ready_in_resp", 64'(miss_ready), 64'd0);
        step();
        chk("t6_idle_gap", 64'(miss_ready), 64'd1);
        step();
        miss_valid = 1'b0;
        chk("t6_second_req", 64'({mem_req_valid, mem_req_addr}), 64'({1'b1, 32'h44}));
        step();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h2222_0044;
        step();
        mem_rsp_valid = 1'b0;
        chk("t6_fill1", 64'({fill_en, fill_index}), 64'({1'b1, 3'd1}));
        step();
        chk("t6_rsp1", 64'({rsp_valid, rsp_data}), 64'({1'b1, 32'h2222_0044}));
        step();
        step();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
